// File: rtl/uart_wrapper.sv
// Full-duplex 8N1 UART that pairs received bytes into a 16-bit command and transmits single response bytes.
// Latency: cmd_rdy one clk after the low byte's stop sample, tx_done 10*BAUD_DIV clks after trmt; no backpressure, so trmt during a frame is dropped.
module uart_wrapper #(
  parameter int BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SHIFT = 1'b1;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] rx_baud_q, rx_baud_d;
  logic [3:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_byte_vld_q, rx_byte_vld_d;
  logic        asm_low_q, asm_low_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic [0:0]  tx_state_q, tx_state_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [15:0] tx_baud_q, tx_baud_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        tx_done_q, tx_done_d;
  logic        rx_fall;

  // Synchronizer and edge-history flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_baud_d     = rx_baud_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_byte_vld_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_baud_d  = 16'd0;
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = 16'd0;
          rx_bit_d   = 4'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = 16'd0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 4'd7) begin
            rx_bit_d   = 4'd0;
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      default: begin
        // A low stop sample is a framing error: the byte never reaches the assembler.
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d     = 16'd0;
          rx_state_d    = RX_IDLE;
          rx_byte_vld_d = rx_sync_q;
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    asm_low_d = asm_low_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end
    // Evaluated after the clear so a completing command wins over a coincident acknowledge.
    if (rx_byte_vld_q) begin
      if (!asm_low_q) begin
        cmd_d[15:8] = rx_shift_q;
        asm_low_d   = 1'b1;
        cmd_rdy_d   = 1'b0;
      end else begin
        cmd_d[7:0] = rx_shift_q;
        asm_low_d  = 1'b0;
        cmd_rdy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q    <= RX_IDLE;
      rx_baud_q     <= 16'd0;
      rx_bit_q      <= 4'd0;
      rx_shift_q    <= 8'd0;
      rx_byte_vld_q <= 1'b0;
      asm_low_q     <= 1'b0;
      cmd_q         <= 16'h0000;
      cmd_rdy_q     <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_baud_q     <= rx_baud_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_byte_vld_q <= rx_byte_vld_d;
      asm_low_q     <= asm_low_d;
      cmd_q         <= cmd_d;
      cmd_rdy_q     <= cmd_rdy_d;
    end
  end

  // Ones shift in from the top, so the line returns high by itself once the stop bit leaves.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_done_d  = tx_done_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (trmt) begin
          tx_state_d = TX_SHIFT;
          tx_shift_d = {1'b1, resp, 1'b0};
          tx_baud_d  = 16'd0;
          tx_bit_d   = 4'd0;
          tx_done_d  = 1'b0;
        end
      end
      default: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = 16'd0;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          if (tx_bit_q == 4'd9) begin
            tx_bit_d   = 4'd0;
            tx_state_d = TX_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_baud_d = tx_baud_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= 10'h3FF;
      tx_baud_q  <= 16'd0;
      tx_bit_q   <= 4'd0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX      = tx_shift_q[0];
  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign tx_done = tx_done_q;

endmodule

// File: doc/uart_wrapper.md
UART_WRAPPER -- requirements
Module: uart_wrapper

Interface
REQ-001 Parameter BAUD_DIV SHALL be: default 5208; clk cycles per bit period (50 MHz / 9600 baud); legal range 16..65535.
REQ-002 Port clk SHALL be: input, 1 bit, system clock; all state on rising edge.
REQ-003 Port rst SHALL be: input, 1 bit; reset is asynchronous and active-high.
REQ-004 Port RX SHALL be: input, 1 bit, serial line from BLE module, 8N1, idle high.
REQ-005 Port TX SHALL be: output, 1 bit, serial line to BLE module, 8N1, idle high.
REQ-006 Port cmd SHALL be: output, 16 bits, last assembled command, high byte received first.
REQ-007 Port cmd_rdy SHALL be: output, 1 bit, a complete command is held on cmd.
REQ-008 Port clr_cmd_rdy SHALL be: input, 1 bit, single-cycle consumer acknowledge.
REQ-009 Port resp SHALL be: input, 8 bits, response byte to transmit (0xA5 done, 0x5A ack).
REQ-010 Port trmt SHALL be: input, 1 bit, single-cycle request to send resp.
REQ-011 Port tx_done SHALL be: output, 1 bit, last requested byte fully shifted out.

Function
REQ-012 RX SHALL pass through a two-flop synchronizer, both flops preset to 1.
REQ-013 Receiver states SHALL be IDLE -> START -> DATA -> STOP -> IDLE; IDLE exits on a synchronized falling edge.
REQ-014 Receiver SHALL sample start at BAUD_DIV/2 cycles after the edge, then each data and stop bit BAUD_DIV cycles apart; data LSB first.
REQ-015 Start sample reading 1 SHALL be treated as a glitch: return to IDLE, no byte produced.
REQ-016 Stop sample reading 0 (framing error) SHALL discard the byte; assembler state unchanged.
REQ-017 Assembler SHALL have states HIGH and LOW; valid byte in HIGH -> latch into cmd[15:8], go LOW; valid byte in LOW -> latch into cmd[7:0], go HIGH.
REQ-018 cmd_rdy SHALL set on the clk after the LOW-byte stop sample.
REQ-019 cmd_rdy SHALL clear on clr_cmd_rdy, or when a new HIGH byte is latched.
REQ-020 If set and clr_cmd_rdy occur in the same cycle, set SHALL win.
REQ-021 cmd[7:0] SHALL hold its value while the assembler is in LOW, so no half-updated command is presented.
REQ-022 Transmitter states SHALL be IDLE -> SHIFT; trmt in IDLE loads {1, resp, 0} into a 10-bit shift register and clears tx_done.
REQ-023 Transmitter SHALL shift one bit per BAUD_DIV cycles, LSB first, with TX driven from register bit 0.
REQ-024 After 10 bit periods the transmitter SHALL return to IDLE, set tx_done and hold TX = 1.
REQ-025 trmt while in SHIFT SHALL be ignored; current frame unaffected.
REQ-026 Receiver and transmitter SHALL operate concurrently and independently (full duplex).
REQ-027 Baud counters SHALL be 16 bits wide; bit counters SHALL be 4 bits wide; neither wraps within a frame.

Reset
REQ-028 rst SHALL force: RX/TX FSMs to IDLE, assembler to HIGH, cmd = 16'h0000, cmd_rdy = 0, tx_done = 0, TX = 1, counters = 0.
REQ-029 rst asserted mid-frame SHALL abort the frame; first valid frame after release SHALL be treated as a HIGH byte.

Verification
REQ-030 Bench SHALL serialize 0x43 then 0x21 on RX -> cmd = 16'h4321, with cmd_rdy rising one clk after the second stop sample.
REQ-031 Bench SHALL pulse clr_cmd_rdy one cycle -> cmd_rdy = 0 next clk, cmd still 16'h4321; the same test SHALL repeat with set and clear coincident -> cmd_rdy = 1.
REQ-032 Bench SHALL send 0x12 with stop bit 0, then 0x34, 0x56 -> cmd = 16'h3456, no cmd_rdy between.
REQ-033 Bench SHALL send resp = 0xA5 with trmt -> TX bits 0,1,0,1,0,0,1,0,1,1 each BAUD_DIV cycles, tx_done high 10*BAUD_DIV cycles after trmt; a second trmt mid-frame is ignored.
REQ-034 Bench SHALL assert rst during the DATA bits of a high byte, then send 0xAB, 0xCD -> cmd = 16'hABCD, cmd_rdy = 1.
REQ-035 Bench SHALL inject a 3-cycle low glitch on RX in IDLE -> no byte, assembler stays HIGH.
